dram_read_engine: RTL and testbench

//  Responder for the kick/busy DRAM read-request interface driven by the frame copy/filter masters.

---
 rtl/dram_read_engine_pkg.sv | 18 +
 rtl/dram_read_engine_if.sv | 38 +++
 rtl/dram_read_engine_burst_calc.sv | 23 ++
 rtl/dram_read_engine.sv | 119 +++++++++++
 tb/tb_dram_read_engine.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_read_engine_pkg.sv
// Shared types and constants for the DRAM read engine: FSM states, fixed AXI encodings and
// the 4 KB page helper used by the burst splitter.
package dram_read_engine_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StAddr, StData} state_e;

  localparam logic [2:0]  AxiSize4B    = 3'b010;
  localparam logic [1:0]  AxiBurstIncr = 2'b01;
  localparam int unsigned PageBytes    = 4096;

  // Words left before the next 4 KB boundary (1..1024) for a word-aligned page offset.
  function automatic logic [10:0] words_to_page(input logic [11:0] page_off);
    logic [12:0] bytes_left;
    bytes_left = 13'(PageBytes) - {1'b0, page_off};
    return bytes_left[12:2];
  endfunction

endpackage

// File: rtl/dram_read_engine_if.sv
// Request (kick/busy/buffer) and AXI4 read-channel bundle for the DRAM read engine.
// The slave modport is the engine's view; master is the requester plus AXI slave environment.
interface dram_read_engine_if;

  logic        kick;
  logic        busy;
  logic [31:0] read_num;
  logic [31:0] read_addr;
  logic [31:0] buf_dout;
  logic        buf_we;

  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arid;

  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;

  modport slave (
    input  kick, read_num, read_addr, m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
    output busy, buf_dout, buf_we, m_araddr, m_arlen, m_arvalid, m_arsize, m_arburst, m_arid,
           m_rready
  );

  modport master (
    output kick, read_num, read_addr, m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  busy, buf_dout, buf_we, m_araddr, m_arlen, m_arvalid, m_arsize, m_arburst, m_arid,
           m_rready
  );

endinterface

// File: rtl/dram_read_engine_burst_calc.sv
// Combinational burst sizing: beats = min(rem, MAX_BURST, words left in the current 4 KB page).
module dram_read_engine_burst_calc
  import dram_read_engine_pkg::*;
#(
  parameter int unsigned MAX_BURST = 64
) (
  input  logic [31:0] rem,
  input  logic [11:0] page_off,
  output logic [8:0]  beats
);

  localparam logic [31:0] MaxBurst = 32'(MAX_BURST);

  logic [10:0] page_words;
  logic [8:0]  rem_clip;

  always_comb begin
    page_words = words_to_page(page_off);
    rem_clip   = (rem > MaxBurst) ? 9'(MAX_BURST) : rem[8:0];
    beats      = (page_words < {2'b00, rem_clip}) ? page_words[8:0] : rem_clip;
  end

endmodule

// File: rtl/dram_read_engine.sv
// DRAM read engine: accepts a kick request, splits it into AXI4 INCR read bursts and streams the
// returned words to buf_dout/buf_we. Define DRAM_READ_RESP_CHECK_EN for err_sticky/err_cnt ports.
module dram_read_engine
  import dram_read_engine_pkg::*;
#(
  parameter int unsigned MAX_BURST = 64,
  parameter logic [3:0]  AXI_ID    = 4'h0
) (
  input  logic                 CLK,
  input  logic                 RST,
  dram_read_engine_if.slave    bus
`ifdef DRAM_READ_RESP_CHECK_EN
  ,
  output logic                 err_sticky,
  output logic [15:0]          err_cnt
`endif
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, rem_q, araddr_q;
  logic [8:0]  beats_q, beat_cnt_q, beats;
  logic [7:0]  arlen_q;
  logic        r_hs, last_beat;

  dram_read_engine_burst_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .rem      (rem_q),
    .page_off (addr_q[11:0]),
    .beats    (beats)
  );

  assign r_hs      = bus.m_rvalid && (state_q == StData);
  // Burst end comes from the local beat count; RLAST never steers the FSM.
  assign last_beat = (beat_cnt_q == beats_q - 9'd1);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.kick) state_d = StCalc;
      StCalc: state_d = (beats == 9'd0) ? StIdle : StAddr;
      StAddr: if (bus.m_arready) state_d = StData;
      StData: if (r_hs && last_beat) state_d = StCalc;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (bus.kick) begin
          addr_q <= {bus.read_addr[31:2], 2'b00};
          rem_q  <= bus.read_num;
        end
        StCalc: if (beats != 9'd0) begin
          beats_q    <= beats;
          beat_cnt_q <= '0;
          araddr_q   <= addr_q;
          arlen_q    <= 8'(beats - 9'd1);
        end
        StAddr: ;
        StData: if (r_hs) begin
          if (last_beat) begin
            addr_q <= addr_q + {21'd0, beats_q, 2'b00};
            rem_q  <= rem_q - {23'd0, beats_q};
          end else begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.m_arvalid = (state_q == StAddr);
    bus.m_rready  = (state_q == StData);
    bus.m_araddr  = araddr_q;
    bus.m_arlen   = arlen_q;
    bus.m_arsize  = AxiSize4B;
    bus.m_arburst = AxiBurstIncr;
    bus.m_arid    = AXI_ID;
    bus.buf_we    = r_hs;
    bus.buf_dout  = bus.m_rdata;
  end

`ifdef DRAM_READ_RESP_CHECK_EN
  logic beat_err;
  assign beat_err = r_hs && ((bus.m_rresp != 2'b00) || (bus.m_rlast != last_beat));

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (state_q == StIdle && bus.kick) err_sticky <= 1'b0;
      else if (beat_err)                 err_sticky <= 1'b1;
      if (beat_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{bus.m_rresp, bus.m_rlast};
`endif

endmodule

// File: tb/tb_dram_read_engine.sv
// Directed bench for dram_read_engine: behavioural AXI read slave (data = ~address) plus
// per-scenario tasks checking AR sequence, returned words and busy timing.
module tb_dram_read_engine;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dram_read_engine_if bus();

`ifdef DRAM_READ_RESP_CHECK_EN
  logic        err_sticky;
  logic [15:0] err_cnt;
`endif

  dram_read_engine #(
    .MAX_BURST (64),
    .AXI_ID    (4'h0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus)
`ifdef DRAM_READ_RESP_CHECK_EN
    ,
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ar_addrs[$];
  logic [7:0]  ar_lens[$];
  logic [31:0] words[$];
  int          busy_cycles = 0;

  bit          stall_en        = 1'b0;
  int          bad_resp_beat   = -1;
  int          early_last_beat = -1;

  bit          r_active = 1'b0;
  logic [31:0] r_addr   = '0;
  int          r_left   = 0;
  int          r_beat   = 0;

  // AXI slave model and monitor; drives at negedge, observes just after.
  always @(negedge CLK) begin
    if (RST) begin
      r_active      = 1'b0;
      bus.m_rvalid  = 1'b0;
      bus.m_arready = 1'b0;
      bus.m_rlast   = 1'b0;
      bus.m_rresp   = 2'b00;
    end else begin
      bus.m_rvalid  = r_active && (!stall_en || $urandom_range(0, 1) == 1);
      bus.m_rdata   = ~r_addr;
      bus.m_rlast   = (r_left == 1) || (r_beat == early_last_beat);
      bus.m_rresp   = (r_beat == bad_resp_beat) ? 2'b10 : 2'b00;
      bus.m_arready = !r_active && (!stall_en || $urandom_range(0, 2) == 0);
    end
    #1;
    if (bus.busy) busy_cycles++;
    if (bus.buf_we) words.push_back(bus.buf_dout);
    if (bus.m_arvalid && bus.m_arready) begin
      ar_addrs.push_back(bus.m_araddr);
      ar_lens.push_back(bus.m_arlen);
      r_active = 1'b1;
      r_addr   = bus.m_araddr;
      r_left   = int'(bus.m_arlen) + 1;
      r_beat   = 0;
    end else if (bus.m_rvalid && bus.m_rready) begin
      r_addr = r_addr + 32'd4;
      r_left--;
      r_beat++;
      if (r_left == 0) r_active = 1'b0;
    end
  end

  task automatic clear_logs();
    ar_addrs.delete();
    ar_lens.delete();
    words.delete();
    busy_cycles = 0;
  endtask

  task automatic kick_req(input logic [31:0] addr, input logic [31:0] num);
    @(negedge CLK);
    bus.read_addr = addr;
    bus.read_num  = num;
    bus.kick      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      #2;
      if (bus.busy) break;
    end
    bus.kick = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL kick_accept: busy=%0b, required 1", bus.busy);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      #2;
      if (!bus.busy) break;
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", bus.busy, budget);
    end
  endtask

  task automatic check_data(input string name, input logic [31:0] base, input int num);
    int errs = 0;
    n_checks++;
    if (words.size() != num) begin
      n_fail++;
      $display("FAIL %s_count: got %0d words, required %0d", name, words.size(), num);
    end
    foreach (words[i]) if (words[i] !== ~(base + 32'(4 * i))) errs++;
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL %s_data: %0d words wrong, required 0", name, errs);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    #2;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %0b, required 0", bus.busy); end
    n_checks++;
    if (bus.m_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL rst_arvalid: %0b, required 0", bus.m_arvalid);
    end
    n_checks++;
    if (bus.m_rready !== 1'b0) begin
      n_fail++; $display("FAIL rst_rready: %0b, required 0", bus.m_rready);
    end
    n_checks++;
    if (bus.buf_we !== 1'b0) begin n_fail++; $display("FAIL rst_buf_we: %0b, required 0", bus.buf_we); end
    n_checks++;
    if (bus.m_araddr !== 32'h0 || bus.m_arlen !== 8'h0) begin
      n_fail++; $display("FAIL rst_ar: addr=%h len=%0d, required 0/0", bus.m_araddr, bus.m_arlen);
    end
    n_checks++;
    if (bus.m_arsize !== 3'b010 || bus.m_arburst !== 2'b01 || bus.m_arid !== 4'h0) begin
      n_fail++;
      $display("FAIL ar_const: size=%b burst=%b id=%h, required 010/01/0",
               bus.m_arsize, bus.m_arburst, bus.m_arid);
    end
    RST = 1'b0;
  endtask

  task automatic test_single_burst();
    clear_logs();
    kick_req(32'h0, 32'd64);
    wait_idle(500);
    n_checks++;
    if (ar_addrs.size() != 1 || ar_addrs[0] !== 32'h0 || ar_lens[0] !== 8'd63) begin
      n_fail++;
      $display("FAIL t1_ar: %0d ARs first addr=%h len=%0d, required 1 @0 len 63",
               ar_addrs.size(), ar_addrs[0], ar_lens[0]);
    end
    check_data("t1", 32'h0, 64);
  endtask

  task automatic test_multi_burst();
    int bad = 0;
    clear_logs();
    kick_req(32'h0, 32'd1600);
    wait_idle(4000);
    n_checks++;
    if (ar_addrs.size() != 25) begin
      n_fail++; $display("FAIL t2_ar_count: %0d, required 25", ar_addrs.size());
    end
    foreach (ar_addrs[i]) if (ar_addrs[i] !== 32'(i * 256) || ar_lens[i] !== 8'd63) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL t2_ar_seq: %0d bad ARs, required 0", bad); end
    check_data("t2", 32'h0, 1600);
  endtask

  task automatic test_4k_split();
    clear_logs();
    kick_req(32'h0000_0FF0, 32'd8);
    wait_idle(200);
    n_checks++;
    if (ar_addrs.size() != 2 || ar_addrs[0] !== 32'h0FF0 || ar_lens[0] !== 8'd3 ||
        ar_addrs[1] !== 32'h1000 || ar_lens[1] !== 8'd3) begin
      n_fail++;
      $display("FAIL t3_split: %0d ARs %h/%0d %h/%0d, required 0ff0/3 1000/3", ar_addrs.size(),
               ar_addrs[0], ar_lens[0], ar_addrs[1], ar_lens[1]);
    end
    check_data("t3", 32'h0FF0, 8);
  endtask

  task automatic test_zero_and_ignored_kick();
    clear_logs();
    kick_req(32'h0000_1234, 32'd0);
    repeat (4) @(negedge CLK);
    #2;
    n_checks++;
    if (busy_cycles != 1) begin
      n_fail++; $display("FAIL t4_busy_pulse: %0d cycles, required 1", busy_cycles);
    end
    n_checks++;
    if (ar_addrs.size() != 0) begin
      n_fail++; $display("FAIL t4_no_ar: %0d ARs, required 0", ar_addrs.size());
    end
    clear_logs();
    kick_req(32'h0000_2000, 32'd16);
    @(negedge CLK);
    bus.read_addr = 32'h0000_9000;
    bus.read_num  = 32'd5;
    bus.kick      = 1'b1;
    repeat (3) @(negedge CLK);
    bus.kick = 1'b0;
    wait_idle(200);
    n_checks++;
    if (ar_addrs.size() != 1 || ar_addrs[0] !== 32'h2000 || ar_lens[0] !== 8'd15) begin
      n_fail++;
      $display("FAIL t4_ignored_kick: %0d ARs first %h/%0d, required 1 @2000 len 15",
               ar_addrs.size(), ar_addrs[0], ar_lens[0]);
    end
    check_data("t4", 32'h2000, 16);
  endtask

  task automatic test_stalls();
    logic [31:0] exp_addr [4] = '{32'h10000, 32'h10100, 32'h10200, 32'h10300};
    logic [7:0]  exp_len  [4] = '{8'd63, 8'd63, 8'd63, 8'd7};
    int bad = 0;
    clear_logs();
    stall_en = 1'b1;
    kick_req(32'h0001_0000, 32'd200);
    wait_idle(5000);
    stall_en = 1'b0;
    n_checks++;
    if (ar_addrs.size() != 4) begin
      n_fail++; $display("FAIL t5_ar_count: %0d, required 4", ar_addrs.size());
    end
    foreach (ar_addrs[i]) if (i < 4 && (ar_addrs[i] !== exp_addr[i] || ar_lens[i] !== exp_len[i])) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL t5_ar_seq: %0d bad ARs, required 0", bad); end
    check_data("t5", 32'h0001_0000, 200);
  endtask

  task automatic test_reset_mid_burst();
    clear_logs();
    kick_req(32'h0000_3000, 32'd64);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    #2;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.m_arvalid !== 1'b0 || bus.m_rready !== 1'b0 ||
        bus.buf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_reset: busy=%0b arvalid=%0b rready=%0b buf_we=%0b, required all 0",
               bus.busy, bus.m_arvalid, bus.m_rready, bus.buf_we);
    end
    n_checks++;
    if (bus.m_araddr !== 32'h0) begin
      n_fail++; $display("FAIL t6_araddr: %h, required 0", bus.m_araddr);
    end
    RST = 1'b0;
    clear_logs();
    kick_req(32'h0000_4000, 32'd4);
    wait_idle(200);
    n_checks++;
    if (ar_addrs.size() != 1 || ar_addrs[0] !== 32'h4000 || ar_lens[0] !== 8'd3) begin
      n_fail++;
      $display("FAIL t6_after_reset: %0d ARs first %h/%0d, required 1 @4000 len 3",
               ar_addrs.size(), ar_addrs[0], ar_lens[0]);
    end
    check_data("t6", 32'h4000, 4);
  endtask

`ifdef DRAM_READ_RESP_CHECK_EN
  task automatic test_resp_check();
    n_checks++;
    if (err_cnt !== 16'd0 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL t7_clean: cnt=%0d sticky=%0b, required 0/0", err_cnt, err_sticky);
    end
    clear_logs();
    bad_resp_beat   = 5;
    early_last_beat = 9;
    kick_req(32'h0000_5000, 32'd16);
    wait_idle(200);
    bad_resp_beat   = -1;
    early_last_beat = -1;
    n_checks++;
    if (err_cnt !== 16'd2 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL t7_errors: cnt=%0d sticky=%0b, required 2/1", err_cnt, err_sticky);
    end
    check_data("t7", 32'h5000, 16);
    clear_logs();
    kick_req(32'h0000_6000, 32'd4);
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL t7_sticky_clear: %0b, required 0", err_sticky);
    end
    wait_idle(200);
    n_checks++;
    if (err_cnt !== 16'd2) begin
      n_fail++; $display("FAIL t7_cnt_hold: %0d, required 2", err_cnt);
    end
  endtask
`endif

  initial begin
    bus.kick      = 1'b0;
    bus.read_addr = '0;
    bus.read_num  = '0;
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rresp   = 2'b00;
    bus.m_rlast   = 1'b0;
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_4k_split();
    test_zero_and_ignored_kick();
    test_stalls();
    test_reset_mid_burst();
`ifdef DRAM_READ_RESP_CHECK_EN
    test_resp_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
